// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// The m-control bit indices match the EX/MEM register layout.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Layout of the 3-bit m-control field carried by ID/EX and EX/MEM.
    localparam int unsigned M_W         = 3;
    localparam int unsigned MC_BRANCH   = 2;
    localparam int unsigned MC_MEMREAD  = 1;
    localparam int unsigned MC_MEMWRITE = 0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic idex_flush;
        logic exmem_hold;
        logic exmem_flush;
        logic pcsrc;
        logic dmem_req;
    } ctrl_t;

    function automatic logic [M_W-1:0] pack_mctrl(input logic branch,
                                                  input logic memread,
                                                  input logic memwrite);
        logic [M_W-1:0] m;
        m              = '0;
        m[MC_BRANCH]   = branch;
        m[MC_MEMREAD]  = memread;
        m[MC_MEMWRITE] = memwrite;
        return m;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard comparator: the load in EX writes a register the
// instruction in ID reads. Writes to $zero never create a dependency.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    output logic       lu
);

    always_comb begin
        lu = ex_memread && (ex_rt != REG_ZERO) &&
             ((ex_rt == id_rs) || (ex_rt == id_rt));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use bubbles,
// branch resolution at MEM, multi-cycle data-memory freeze and timeout error.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TO_W    = $clog2(TIMEOUT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             mem_memread,
    input  logic             mem_memwrite,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_flush,
    output logic             exmem_hold,
    output logic             exmem_flush,
    output logic             pcsrc,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count
);

    state_t          state, state_nxt;
    logic [TO_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [M_W-1:0]  mem_m;
    logic            acc, mstall, lu, br;
    ctrl_t           ctrl;

    assign mem_m  = pack_mctrl(mem_branch, mem_memread, mem_memwrite);
    assign acc    = mem_m[MC_MEMREAD] | mem_m[MC_MEMWRITE];
    assign mstall = acc & ~dmem_ready;
    assign br     = mem_m[MC_BRANCH] & mem_zero;

    hazard_detect u_hazard_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .lu         (lu)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_err     <= 1'b0;
            stall_count <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state_nxt == ERR) begin
                mem_err <= 1'b1;
            end
            if (!ctrl.pc_write && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

    // Leaving MEM_WAIT on ~acc covers an access withdrawn before completion.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (mstall) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = TO_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!mstall) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
                    state_nxt = ERR;
                end else begin
                    wait_cnt_nxt = wait_cnt + TO_W'(1);
                end
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Mealy outputs; a taken branch outranks load-use since ID is flushed.
    always_comb begin
        ctrl = '0;
        if (!reset) begin
            if (state == ERR) begin
                ctrl.exmem_hold = 1'b1;
            end else begin
                ctrl.dmem_req = acc;
                if (mstall) begin
                    ctrl.exmem_hold = 1'b1;
                end else if (br) begin
                    ctrl.pcsrc       = 1'b1;
                    ctrl.pc_write    = 1'b1;
                    ctrl.ifid_write  = 1'b1;
                    ctrl.ifid_flush  = 1'b1;
                    ctrl.idex_flush  = 1'b1;
                    ctrl.exmem_flush = 1'b1;
                end else if (lu) begin
                    ctrl.idex_bubble = 1'b1;
                end else begin
                    ctrl.pc_write   = 1'b1;
                    ctrl.ifid_write = 1'b1;
                end
            end
        end
    end

    assign dmem_req    = ctrl.dmem_req;
    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_bubble = ctrl.idex_bubble;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_hold  = ctrl.exmem_hold;
    assign exmem_flush = ctrl.exmem_flush;
    assign pcsrc       = ctrl.pcsrc;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl built with TIMEOUT=4 and CNT_W=4.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TIMEOUT = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             ex_memread, mem_branch, mem_zero;
    logic             mem_memread, mem_memwrite, dmem_ready;
    logic             dmem_req, pc_write, ifid_write, ifid_flush;
    logic             idex_bubble, idex_flush, exmem_hold, exmem_flush;
    logic             pcsrc, mem_err;
    logic [CNT_W-1:0] stall_count;

    int errors = 0;
    int checks = 0;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_memread   (ex_memread),
        .ex_rt        (ex_rt),
        .mem_branch   (mem_branch),
        .mem_zero     (mem_zero),
        .mem_memread  (mem_memread),
        .mem_memwrite (mem_memwrite),
        .dmem_ready   (dmem_ready),
        .dmem_req     (dmem_req),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .idex_flush   (idex_flush),
        .exmem_hold   (exmem_hold),
        .exmem_flush  (exmem_flush),
        .pcsrc        (pcsrc),
        .mem_err      (mem_err),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_rt = '0; ex_memread = 1'b0;
        mem_branch = 1'b0; mem_zero = 1'b0; mem_memread = 1'b0;
        mem_memwrite = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        mem_memread = 1'b1;
        #1;
        checks++;
        if ({pc_write, ifid_write, dmem_req, exmem_hold, pcsrc} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {pc_write, ifid_write, dmem_req, exmem_hold, pcsrc});
        end
        checks++;
        if ({mem_err, stall_count} !== 5'b0) begin
            errors++;
            $display("FAIL reset_regs: got %b want 00000", {mem_err, stall_count});
        end
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({pc_write, ifid_write} !== 2'b11) begin
            errors++;
            $display("FAIL reset_release: got %b want 11", {pc_write, ifid_write});
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_rt = 5'd3;
        #1;
        checks++;
        if ({pc_write, ifid_write, idex_bubble} !== 3'b001) begin
            errors++;
            $display("FAIL load_use: got %b want 001", {pc_write, ifid_write, idex_bubble});
        end
        @(posedge clk); #1;
        checks++;
        if (stall_count !== 4'd1) begin
            errors++;
            $display("FAIL load_use_count: got %0d want 1", stall_count);
        end
        @(negedge clk);
        ex_memread = 1'b0;
        #1;
        checks++;
        if ({pc_write, ifid_write, idex_bubble} !== 3'b110) begin
            errors++;
            $display("FAIL load_use_release: got %b want 110", {pc_write, ifid_write, idex_bubble});
        end
    endtask

    task automatic test_no_stall();
        apply_reset();
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        #1;
        checks++;
        if ({pc_write, idex_bubble} !== 2'b10) begin
            errors++;
            $display("FAIL rt_zero: got %b want 10", {pc_write, idex_bubble});
        end
        @(negedge clk);
        ex_rt = 5'd9; id_rs = 5'd1; id_rt = 5'd10;
        #1;
        checks++;
        if ({pc_write, idex_bubble} !== 2'b10) begin
            errors++;
            $display("FAIL no_match: got %b want 10", {pc_write, idex_bubble});
        end
        @(negedge clk);
        id_rt = 5'd9;
        #1;
        checks++;
        if ({pc_write, idex_bubble} !== 2'b01) begin
            errors++;
            $display("FAIL rt_match: got %b want 01", {pc_write, idex_bubble});
        end
    endtask

    task automatic test_branch();
        apply_reset();
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        mem_branch = 1'b1; mem_zero = 1'b1;
        #1;
        checks++;
        if ({pcsrc, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, idex_bubble} !== 7'b1111110) begin
            errors++;
            $display("FAIL branch_taken: got %b want 1111110",
                     {pcsrc, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, idex_bubble});
        end
        @(negedge clk);
        mem_zero = 1'b0;
        #1;
        checks++;
        if ({pcsrc, ifid_flush, idex_flush, exmem_flush, idex_bubble} !== 5'b00001) begin
            errors++;
            $display("FAIL branch_not_taken: got %b want 00001",
                     {pcsrc, ifid_flush, idex_flush, exmem_flush, idex_bubble});
        end
    endtask

    task automatic test_mem_wait();
        apply_reset();
        mem_memread = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            #1;
            checks++;
            if ({dmem_req, pc_write, ifid_write, exmem_hold} !== 4'b1001) begin
                errors++;
                $display("FAIL mem_wait_c%0d: got %b want 1001", i, {dmem_req, pc_write, ifid_write, exmem_hold});
            end
            @(negedge clk);
        end
        checks++;
        if (dut.state !== MEM_WAIT) begin
            errors++;
            $display("FAIL mem_wait_state: got %0d want %0d", dut.state, MEM_WAIT);
        end
        dmem_ready = 1'b1;
        #1;
        checks++;
        if ({dmem_req, pc_write, ifid_write, exmem_hold} !== 4'b1110) begin
            errors++;
            $display("FAIL mem_wait_done: got %b want 1110", {dmem_req, pc_write, ifid_write, exmem_hold});
        end
        @(negedge clk);
        checks++;
        if (dut.state !== RUN || stall_count !== 4'd3) begin
            errors++;
            $display("FAIL mem_wait_end: got state=%0d cnt=%0d want state=0 cnt=3", dut.state, stall_count);
        end
        // zero-wait access: ready together with acc in RUN
        #1;
        checks++;
        if ({dmem_req, pc_write} !== 2'b11) begin
            errors++;
            $display("FAIL zero_wait: got %b want 11", {dmem_req, pc_write});
        end
        @(negedge clk);
        checks++;
        if (dut.state !== RUN) begin
            errors++;
            $display("FAIL zero_wait_state: got %0d want 0", dut.state);
        end
        // access withdrawn mid-wait
        dmem_ready = 1'b0;
        @(negedge clk);
        mem_memread = 1'b0;
        @(negedge clk);
        checks++;
        if (dut.state !== RUN || mem_err !== 1'b0 || stall_count !== 4'd4) begin
            errors++;
            $display("FAIL acc_drop: got state=%0d err=%b cnt=%0d want 0 0 4", dut.state, mem_err, stall_count);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        mem_memwrite = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++;
            if ({dmem_req, pc_write, exmem_hold, mem_err} !== 4'b1010) begin
                errors++;
                $display("FAIL timeout_c%0d: got %b want 1010", i, {dmem_req, pc_write, exmem_hold, mem_err});
            end
            @(negedge clk);
        end
        checks++;
        if ({mem_err, dmem_req, pc_write, exmem_hold} !== 4'b1001 || stall_count !== 4'd4) begin
            errors++;
            $display("FAIL timeout_err: got %b cnt=%0d want 1001 cnt=4", {mem_err, dmem_req, pc_write, exmem_hold}, stall_count);
        end
        dmem_ready = 1'b1; mem_branch = 1'b1; mem_zero = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            #1;
            checks++;
            if ({mem_err, dmem_req, pc_write, ifid_write, exmem_hold, pcsrc, ifid_flush} !== 7'b1000100) begin
                errors++;
                $display("FAIL err_frozen_c%0d: got %b want 1000100", i,
                         {mem_err, dmem_req, pc_write, ifid_write, exmem_hold, pcsrc, ifid_flush});
            end
            @(negedge clk);
        end
        checks++;
        if (stall_count !== 4'd7) begin
            errors++;
            $display("FAIL err_count: got %0d want 7", stall_count);
        end
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_err, stall_count} !== 5'b0 || dut.state !== RUN) begin
            errors++;
            $display("FAIL async_reset: got err=%b cnt=%0d state=%0d want 0 0 0", mem_err, stall_count, dut.state);
        end
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        apply_reset();
        ex_memread = 1'b1; ex_rt = 5'd5; id_rt = 5'd5;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 15) begin
                checks++;
                if (stall_count !== 4'hF) begin
                    errors++;
                    $display("FAIL sat_reach: got %h want f", stall_count);
                end
            end
        end
        checks++;
        if (stall_count !== 4'hF) begin
            errors++;
            $display("FAIL sat_hold: got %h want f", stall_count);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline. Drives write-enable, bubble and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers.
- Detects load-use hazards and resolves taken branches at MEM from the EX/MEM branch bit plus ALU zero.
- Freezes the pipeline while a multi-cycle data-memory access is outstanding. Raises a sticky error on memory timeout.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.
- TIMEOUT, 64, maximum cycles spent in MEM_WAIT before error (must be ≥2).
- TO_W, $clog2(TIMEOUT), width of the wait counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- ex_memread  in  1  MemRead control of the instruction in EX (ID/EX m-control).
- ex_rt  in  5  rt (load destination) of the instruction in EX.
- mem_branch  in  1  Branch bit of the EX/MEM m-control field.
- mem_zero  in  1  ALU zero registered in EX/MEM.
- mem_memread  in  1  MemRead of the instruction in MEM.
- mem_memwrite  in  1  MemWrite of the instruction in MEM.
- dmem_ready  in  1  data memory completion, 1-cycle pulse.
- dmem_req  out  1  data memory request, level.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID clear to NOP.
- idex_bubble  out  1  zero ID/EX control fields (load-use bubble).
- idex_flush  out  1  ID/EX clear to NOP.
- exmem_hold  out  1  EX/MEM hold current contents.
- exmem_flush  out  1  EX/MEM clear control fields.
- pcsrc  out  1  select branch target (EX/MEM add_result).
- mem_err  out  1  sticky memory-timeout error.
- stall_count  out  CNT_W  saturating count of cycles with pc_write=0.

Behaviour:
- State register: RUN, MEM_WAIT, ERR. The FSM and counters are clocked on posedge clk. Outputs are combinational from state and inputs (Mealy).
- Reset values: state=RUN, wait_cnt=0, stall_count=0, mem_err=0. While reset is high, all control outputs are 0, including pc_write and ifid_write.

Definitions:
- acc = mem_memread | mem_memwrite.
- mstall = acc & ~dmem_ready.
- lu = ex_memread & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
- br = mem_branch & mem_zero.

Priority in RUN/MEM_WAIT (highest first):
1. mstall → pc_write=0, ifid_write=0, exmem_hold=1, all flush/bubble=0, pcsrc=0.
2. br → pcsrc=1, pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, exmem_flush=1. lu is ignored this cycle because the ID instruction is being flushed.
3. lu → pc_write=0, ifid_write=0, idex_bubble=1.
4. Otherwise pc_write=1 and ifid_write=1; all other controls 0.

dmem_req:
- dmem_req = acc in RUN/MEM_WAIT; 0 in ERR.

Transitions:
- RUN → MEM_WAIT when mstall; wait_cnt ← 1.
- MEM_WAIT → RUN when dmem_ready. In that same cycle the stall releases and br/lu are evaluated normally.
- MEM_WAIT, ~dmem_ready, wait_cnt < TIMEOUT-1 → stay; wait_cnt increments.
- MEM_WAIT, ~dmem_ready, wait_cnt == TIMEOUT-1 → ERR; mem_err ← 1.
- ERR is absorbing until reset. In ERR: pc_write=0, ifid_write=0, exmem_hold=1, all flush=0, dmem_req=0.

Edge cases:
- acc deasserting in MEM_WAIT without dmem_ready → RUN, no error.
- dmem_ready arriving in RUN with acc → no stall, state stays RUN (zero-wait access).
- stall_count: +1 on every cycle with pc_write=0 outside reset, including ERR. Saturates at all-ones.
- ex_rt=0 never causes a stall.
- Reset asserted mid-wait returns immediately to RUN with counters cleared.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum {RUN, MEM_WAIT, ERR};
  - REG_ZERO=5'd0;
  - indices of the Branch/MemRead/MemWrite bits in the 3-bit m-control field, so these bits are wired consistently with the EX/MEM register.
- One sub-module, hazard_detect: purely combinational lu comparator over id_rs, id_rt, ex_memread, ex_rt.

Test Plan:
- Load-use: ex_memread=1, ex_rt=5'd8, id_rs=5'd8, no acc/br → pc_write=0, ifid_write=0, idex_bubble=1 for exactly that cycle; stall_count becomes 1.
- Rt=0 load and non-matching registers: ex_rt=0, id_rs=0, then ex_rt=9, id_rt=10 → no stall, pc_write=1.
- Taken branch: mem_branch=1, mem_zero=1, with a simultaneous lu condition → pcsrc=1, all three flushes=1, idex_bubble=0, pc_write=1. mem_zero=0 → pcsrc=0.
- Memory wait: mem_memread=1, dmem_ready after 3 cycles → dmem_req high for 4 cycles, pc_write=0 and exmem_hold=1 for 3 cycles, state returns to RUN, stall_count=3.
- Timeout: TIMEOUT=4, mem_memwrite=1, dmem_ready never asserted → mem_err=1 after the 4th stalled cycle, dmem_req=0. All outputs stay frozen until reset; async reset mid-cycle clears mem_err and stall_count without waiting for a clock edge.
- Saturation: CNT_W=4 with 20 consecutive stalled cycles → stall_count holds at 4'hF.
